// File: rtl/pal_arb_pkg.sv
// pal_arb_pkg: shared widths and types for the palette lookup arbiter.
//   PAL_IDX_W  width of a palette colour index (32-entry ROM)
//   PAL_CH_W   width of one RGB444 colour channel
//   pal_idx_t  palette index type
//   rgb444_t   packed {r, g, b} colour
package pal_arb_pkg;

  localparam int PAL_IDX_W = 5;
  localparam int PAL_CH_W  = 4;

  typedef logic [PAL_IDX_W-1:0] pal_idx_t;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb444_t;

endpackage

// File: rtl/pal_rr_arbiter.sv
// pal_rr_arbiter: combinational rotate-priority arbiter.
// The search starts at ptr and wraps modulo NUM_REQ; the first asserted
// request wins. The winner and any are reported regardless of enable, so the
// parent can steer the palette index even while the output is stalled; only
// the one-hot grant is qualified by enable.
// Ports:
//   req     in   NUM_REQ  request vector
//   ptr     in   ID_W     highest-priority requester this cycle
//   enable  in   1        allow a grant to be issued
//   grant   out  NUM_REQ  one-hot grant (zero when disabled or idle)
//   winner  out  ID_W     encoded winning requester (0 when idle)
//   any     out  1        at least one request present
module pal_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    w_sum  = '0;
    w_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr and k are both below NUM_REQ, so one conditional subtract wraps
      w_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!any && req[w_idx]) begin
        any    = 1'b1;
        winner = w_idx;
      end
    end
    if (any && enable) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: shares one combinational 32 x 12-bit palette ROM
// between NUM_REQ pixel sources. A round-robin arbiter picks one source per
// cycle, drives its index to the ROM, and registers the returned RGB444 with
// the winner's ID in a single-entry output register (full throughput when
// out_ready stays high, 1-cycle latency).
// Optional feature macro: PAL_TRANSPARENT_KEY_EN -- when defined, an index
// equal to TRANS_IDX returns out_transparent=1 and zero RGB.
// Ports:
//   Clk, Reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (req_ready is one-hot)
//   req_index              packed 5-bit indices, requester i at [5*i +: 5]
//   pal_index              index to the palette ROM
//   pal_red/green/blue     ROM data for pal_index, same cycle
//   out_valid/out_ready    result handshake
//   out_id                 requester that issued the result
//   out_red/green/blue     registered RGB
//   out_transparent        index matched the transparent key
module palette_lookup_arbiter
  import pal_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int TRANS_IDX = 15,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*PAL_IDX_W-1:0]   req_index,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [PAL_IDX_W-1:0]           pal_index,
  input  logic [PAL_CH_W-1:0]            pal_red,
  input  logic [PAL_CH_W-1:0]            pal_green,
  input  logic [PAL_CH_W-1:0]            pal_blue,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic [PAL_CH_W-1:0]            out_red,
  output logic [PAL_CH_W-1:0]            out_green,
  output logic [PAL_CH_W-1:0]            out_blue,
  output logic                           out_transparent
);

  localparam pal_idx_t TRANS_KEY = pal_idx_t'(TRANS_IDX);

  logic               w_can_load;
  logic               w_any;
  logic               w_xfer;
  logic               w_key;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_next_ptr;
  pal_idx_t           w_pal_idx;
  rgb444_t            w_rom_rgb;

  logic               r_out_valid;
  logic [ID_W-1:0]    r_out_id;
  logic [ID_W-1:0]    r_rr_ptr;
  rgb444_t            r_out_rgb;
  logic               r_out_transparent;

  assign w_can_load = ~r_out_valid | out_ready;

  // Reset_n gates the grant directly so no requester sees ready while held
  // in reset, even with valid asserted.
  pal_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .enable (w_can_load & Reset_n),
    .grant  (w_grant),
    .winner (w_winner),
    .any    (w_any)
  );

  assign req_ready = w_grant;
  assign w_xfer    = w_any & w_can_load;

  always_comb begin
    w_pal_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_any && (w_winner == ID_W'(i))) begin
        w_pal_idx = req_index[PAL_IDX_W*i +: PAL_IDX_W];
      end
    end
  end

  assign pal_index  = w_pal_idx;
  assign w_rom_rgb  = '{r: pal_red, g: pal_green, b: pal_blue};
  assign w_next_ptr = (w_winner == ID_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;

`ifdef PAL_TRANSPARENT_KEY_EN
  assign w_key = (w_pal_idx == TRANS_KEY);
`else
  // Key disabled: reduces to constant 0, the compare only keeps TRANS_IDX
  // referenced in this build.
  assign w_key = 1'b0 & (w_pal_idx == TRANS_KEY);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid       <= 1'b0;
      r_out_id          <= '0;
      r_out_rgb         <= '0;
      r_out_transparent <= 1'b0;
      r_rr_ptr          <= '0;
    end else if (w_xfer) begin
      // A load also covers the drain-and-refill case without a bubble.
      r_out_valid       <= 1'b1;
      r_out_id          <= w_winner;
      r_out_rgb         <= w_key ? '0 : w_rom_rgb;
      r_out_transparent <= w_key;
      r_rr_ptr          <= w_next_ptr;
    end else if (out_ready) begin
      r_out_valid       <= 1'b0;
    end
  end

  assign out_valid       = r_out_valid;
  assign out_id          = r_out_id;
  assign out_red         = r_out_rgb.r;
  assign out_green       = r_out_rgb.g;
  assign out_blue        = r_out_rgb.b;
  assign out_transparent = r_out_transparent;

endmodule
